// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone-attached SPI slave (mode 0, MSB first, 8-bit frames).
// SPI pins are oversampled by clk through SYNC_STAGES flops. No logic runs on SCLK.
//
// Optional feature macro: WB_SPI_SLAVE_RXFIFO_EN. When defined, the RX holding
// register becomes a FIFO_DEPTH-entry FIFO and STATUS[15:8] reports the fill count.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   wb_*                Wishbone slave (only wb_adr_i[3:2] decoded)
//   intr                level interrupt, active-high
//   spi_sclk/ss_n/mosi  SPI inputs from the external master
//   spi_miso/miso_oe    SPI output and its output enable
//
// Registers: 0x0 RXDATA, 0x4 TXDATA, 0x8 STATUS, 0xC CTRL.
module wb_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic        spi_sclk,
    input  logic        spi_ss_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    // Async assert, sync deassert.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Input synchronisers plus one-cycle delayed copies for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic sclk_d_q, ss_d_q;
    logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_d_q    <= 1'b0;
            ss_d_q      <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_d_q    <= sclk_s;
            ss_d_q      <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d_q;
    assign sclk_fall = ~sclk_s & sclk_d_q;
    assign ss_fall   = ~ss_s & ss_d_q;
    assign ss_rise   = ss_s & ~ss_d_q;

    // Register state
    logic [7:0] tx_buf_q;
    logic       tx_empty_q, overrun_q, underrun_q;
    logic [2:0] ctrl_q;
    logic       en, rx_ie, txe_ie;
    assign en     = ctrl_q[0];
    assign rx_ie  = ctrl_q[1];
    assign txe_ie = ctrl_q[2];

    // FSM state
    state_e     state_q;
    logic [7:0] shift_tx_q, shift_rx_q;
    logic [3:0] bitcnt_q;
    logic       ur_pend_q;

    // Wishbone decode
    logic ack_q, req, wr, rd_rx, wr_tx, wr_stat, wr_ctrl;
    assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr      = req & wb_we_i & wb_sel_i[0];
    assign rd_rx   = req & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign wr_tx   = wr & (wb_adr_i[3:2] == 2'd1);
    assign wr_stat = wr & (wb_adr_i[3:2] == 2'd2);
    assign wr_ctrl = wr & (wb_adr_i[3:2] == 2'd3);

    logic consume, push, pop, overrun_set, underrun_set;
    logic rx_valid;
    logic [7:0] rx_head, fill;

    assign consume = (state_q == StLoad) | (state_q == StDone);
    assign push    = (state_q == StDone);
    assign pop     = rd_rx & rx_valid;
    // An empty reload between back-to-back frames only counts as underrun once the
    // master actually clocks the next frame.
    assign underrun_set = ((state_q == StLoad) & tx_empty_q) |
                          ((state_q == StShift) & en & ~ss_rise & sclk_rise & ur_pend_q);

`ifdef WB_SPI_SLAVE_RXFIFO_EN
    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic          full, push_ok;

    assign full        = (count_q == (AW+1)'(FIFO_DEPTH));
    // Pop is applied first, so a full FIFO being read this cycle still accepts.
    assign push_ok     = push & (~full | pop);
    assign overrun_set = push & full & ~pop;
    assign rx_valid    = (count_q != '0);
    assign rx_head     = fifo_q[rd_ptr_q];
    assign fill        = 8'(count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= 8'h00;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= shift_rx_q;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    assign overrun_set = push & rx_valid_q & ~pop;
    assign rx_valid    = rx_valid_q;
    assign rx_head     = rx_data_q;
    assign fill        = 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else if (push && !overrun_set) begin
            rx_data_q  <= shift_rx_q;
            rx_valid_q <= 1'b1;
        end else if (pop) begin
            rx_valid_q <= 1'b0;
        end
    end
`endif

    // Wishbone read data, registered alongside ack.
    logic [31:0] rd_data;
    always_comb begin
        rd_data = 32'h0;
        case (wb_adr_i[3:2])
            2'd0: rd_data = {24'h0, rx_valid ? rx_head : 8'h00};
            2'd1: rd_data = {24'h0, tx_buf_q};
            2'd2: rd_data = {16'h0, fill, 3'b000, underrun_q, ~ss_s, overrun_q,
                             tx_empty_q, rx_valid};
            default: rd_data = {29'h0, ctrl_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            wb_dat_o   <= 32'h0;
            tx_buf_q   <= 8'h00;
            tx_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            ctrl_q     <= 3'b000;
        end else begin
            ack_q    <= req;
            wb_dat_o <= (req & ~wb_we_i) ? rd_data : 32'h0;
            if (wr_tx)                    tx_buf_q <= wb_dat_i[7:0];
            // A same-cycle write wins over the consume; the consume used the old buffer.
            if (wr_tx)                    tx_empty_q <= 1'b0;
            else if (consume & ~tx_empty_q) tx_empty_q <= 1'b1;
            overrun_q  <= (overrun_q & ~(wr_stat & wb_dat_i[2])) | overrun_set;
            underrun_q <= (underrun_q & ~(wr_stat & wb_dat_i[4])) | underrun_set;
            if (wr_ctrl)                  ctrl_q <= wb_dat_i[2:0];
        end
    end

    assign wb_ack_o = ack_q;
    assign intr     = (rx_ie & rx_valid) | (txe_ie & tx_empty_q & en);

    // SPI FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_tx_q <= 8'h00;
            shift_rx_q <= 8'h00;
            bitcnt_q   <= 4'd0;
            ur_pend_q  <= 1'b0;
        end else if (!en || ss_rise) begin
            state_q   <= StIdle;
            ur_pend_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ss_fall) state_q <= StLoad;
                end
                StLoad, StDone: begin
                    shift_tx_q <= tx_empty_q ? 8'h00 : tx_buf_q;
                    ur_pend_q  <= (state_q == StDone) & tx_empty_q;
                    bitcnt_q   <= 4'd0;
                    state_q    <= StShift;
                end
                StShift: begin
                    if (sclk_rise) begin
                        shift_rx_q <= {shift_rx_q[6:0], mosi_s};
                        bitcnt_q   <= bitcnt_q + 4'd1;
                        ur_pend_q  <= 1'b0;
                        if (bitcnt_q == 4'd7) state_q <= StDone;
                    end else if (sclk_fall && bitcnt_q != 4'd0) begin
                        // The fall that trails a reload belongs to the previous byte.
                        shift_tx_q <= {shift_tx_q[6:0], 1'b0};
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign spi_miso_oe = (state_q != StIdle);
    assign spi_miso    = spi_miso_oe & shift_tx_q[7];

    logic unused_ok;
    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1],
                         1'(FIFO_DEPTH)};

endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed self-checking bench for wb_spi_slave. Honors WB_SPI_SLAVE_RXFIFO_EN.
module tb_wb_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic        intr, spi_miso, spi_miso_oe;
    logic        spi_sclk = 1'b0, spi_ss_n = 1'b1, spi_mosi = 1'b0;

    int tests = 0;
    int fails = 0;

`ifdef WB_SPI_SLAVE_RXFIFO_EN
    localparam bit FifoOn = 1'b1;
`else
    localparam bit FifoOn = 1'b0;
`endif

    wb_spi_slave dut (
        .clk        (clk),
        .rst        (rst),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_i   (wb_sel_i),
        .wb_stb_i   (wb_stb_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_we_i    (wb_we_i),
        .wb_ack_o   (wb_ack_o),
        .intr       (intr),
        .spi_sclk   (spi_sclk),
        .spi_ss_n   (spi_ss_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    // Expected STATUS: base bits plus fill count when the FIFO is built in.
    function automatic logic [31:0] st(input logic [31:0] base, input int cnt);
        return FifoOn ? (base | (32'(cnt) << 8)) : base;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        bit got = 1'b0;
        wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        q = 32'hx;
        for (int k = 0; k < 16 && !got; k++) begin
            tick(1);
            if (wb_ack_o) begin
                got = 1'b1;
                q = wb_dat_o;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL wb_ack_timeout: adr %h got no ack, required ack within 16 cycles", a);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'h0, q);
    endtask

    // Master: mode 0, MSB first, bits taken from mo[15] downward, half period 8 clk.
    task automatic spi_frame(input logic [15:0] mo, input int n,
                             output logic [15:0] mi, output int oe_cnt);
        mi = 16'h0; oe_cnt = 0;
        spi_ss_n = 1'b0;
        tick(8);
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[15-i];
            tick(8);
            mi = {mi[14:0], spi_miso};
            if (spi_miso_oe) oe_cnt++;
            spi_sclk = 1'b1;
            tick(8);
            spi_sclk = 1'b0;
        end
        tick(8);
        spi_ss_n = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        rst = 1'b0;
        tick(3);
        tests++;
        if ({wb_ack_o, intr, spi_miso, spi_miso_oe} !== 4'b0000 || wb_dat_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ack%b intr%b miso%b oe%b dat %h, required all 0",
                     wb_ack_o, intr, spi_miso, spi_miso_oe, wb_dat_o);
        end
        rst = 1'b1;
        tick(4);
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h2) begin fails++; $display("FAIL reset_status: got %h required 00000002", q); end
        wb_read(32'hC, q);
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h required 0", q); end
        tests++;
        if (intr !== 1'b0 || spi_miso_oe !== 1'b0) begin
            fails++;
            $display("FAIL reset_intr_oe: got intr%b oe%b required 0 0", intr, spi_miso_oe);
        end
    endtask

    task automatic test_basic();
        logic [31:0] q;
        logic [15:0] mi;
        int oe;
        wb_write(32'hC, 32'h3);
        wb_write(32'h4, 32'hA5);
        wb_read(32'h4, q);
        tests++;
        if (q !== 32'hA5) begin fails++; $display("FAIL txdata_rb: got %h required a5", q); end
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL status_txfull: got %h required 0", q); end
        spi_frame({8'h3C, 8'h00}, 8, mi, oe);
        tests++;
        if (mi[7:0] !== 8'hA5 || oe != 8) begin
            fails++;
            $display("FAIL basic_miso: got %h oe %0d required a5 oe 8", mi[7:0], oe);
        end
        wb_read(32'h8, q);
        tests++;
        if (q !== st(32'h3, 1)) begin fails++; $display("FAIL basic_status: got %h required %h", q, st(32'h3, 1)); end
        tests++;
        if (intr !== 1'b1) begin fails++; $display("FAIL basic_intr_set: got %b required 1", intr); end
        wb_read(32'h0, q);
        tests++;
        if (q !== 32'h3C) begin fails++; $display("FAIL basic_rxdata: got %h required 3c", q); end
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h2 || intr !== 1'b0) begin
            fails++;
            $display("FAIL basic_after_pop: got status %h intr %b required 00000002 0", q, intr);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] q;
        logic [15:0] mi;
        int oe;
        spi_frame({8'h55, 8'h00}, 8, mi, oe);
        tests++;
        if (mi[7:0] !== 8'h00) begin fails++; $display("FAIL underrun_miso: got %h required 00", mi[7:0]); end
        wb_read(32'h8, q);
        tests++;
        if (q !== st(32'h13, 1)) begin fails++; $display("FAIL underrun_status: got %h required %h", q, st(32'h13, 1)); end
        wb_write(32'h8, 32'h10);
        wb_read(32'h8, q);
        tests++;
        if (q !== st(32'h3, 1)) begin fails++; $display("FAIL underrun_w1c: got %h required %h", q, st(32'h3, 1)); end
        wb_read(32'h0, q);
        tests++;
        if (q !== 32'h55) begin fails++; $display("FAIL underrun_rx: got %h required 55", q); end
    endtask

    task automatic test_overrun();
        logic [31:0] q;
        logic [15:0] mi;
        int oe;
`ifdef WB_SPI_SLAVE_RXFIFO_EN
        for (int b = 1; b <= 5; b++) spi_frame({8'(b), 8'h00}, 8, mi, oe);
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h417) begin fails++; $display("FAIL fifo_status: got %h required 00000417", q); end
        for (int b = 1; b <= 4; b++) begin
            wb_read(32'h0, q);
            tests++;
            if (q !== 32'(b)) begin fails++; $display("FAIL fifo_rx%0d: got %h required %h", b, q, 32'(b)); end
        end
`else
        spi_frame({8'h11, 8'h00}, 8, mi, oe);
        spi_frame({8'h22, 8'h00}, 8, mi, oe);
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h17) begin fails++; $display("FAIL overrun_status: got %h required 00000017", q); end
        wb_read(32'h0, q);
        tests++;
        if (q !== 32'h11) begin fails++; $display("FAIL overrun_rx: got %h required 11", q); end
`endif
        wb_read(32'h0, q);
        tests++;
        if (q !== 32'h0) begin fails++; $display("FAIL empty_read: got %h required 0", q); end
        wb_write(32'h8, 32'h14);
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h2) begin fails++; $display("FAIL overrun_w1c: got %h required 00000002", q); end
    endtask

    task automatic test_partial();
        logic [31:0] q;
        logic [15:0] mi;
        int oe;
        spi_frame(16'hFFFF, 5, mi, oe);
        spi_frame({8'h81, 8'h00}, 8, mi, oe);
        wb_read(32'h8, q);
        tests++;
        if (q !== st(32'h13, 1)) begin fails++; $display("FAIL partial_status: got %h required %h", q, st(32'h13, 1)); end
        wb_read(32'h0, q);
        tests++;
        if (q !== 32'h81) begin fails++; $display("FAIL partial_rx: got %h required 81", q); end
        wb_write(32'h8, 32'h10);
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h2) begin fails++; $display("FAIL partial_clean: got %h required 00000002", q); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        logic [15:0] mi;
        int oe;
        wb_write(32'h4, 32'h5A);
        spi_frame(16'hC396, 16, mi, oe);
        tests++;
        if (mi !== 16'h5A00 || oe != 16) begin
            fails++;
            $display("FAIL b2b_miso: got %h oe %0d required 5a00 oe 16", mi, oe);
        end
        wb_read(32'h8, q);
        tests++;
        if (q !== (FifoOn ? 32'h213 : 32'h17)) begin
            fails++;
            $display("FAIL b2b_status: got %h required %h", q, FifoOn ? 32'h213 : 32'h17);
        end
        wb_read(32'h0, q);
        tests++;
        if (q !== 32'hC3) begin fails++; $display("FAIL b2b_rx0: got %h required c3", q); end
        if (FifoOn) begin
            wb_read(32'h0, q);
            tests++;
            if (q !== 32'h96) begin fails++; $display("FAIL b2b_rx1: got %h required 96", q); end
        end
        wb_write(32'h8, 32'h14);
    endtask

    task automatic test_disable();
        logic [31:0] q;
        logic [15:0] mi;
        int oe;
        wb_write(32'hC, 32'h4);
        tests++;
        if (intr !== 1'b0) begin fails++; $display("FAIL dis_intr: got %b required 0", intr); end
        spi_frame({8'h77, 8'h00}, 8, mi, oe);
        tests++;
        if (oe != 0) begin fails++; $display("FAIL dis_oe: got %0d oe samples required 0", oe); end
        wb_read(32'h8, q);
        tests++;
        if (q !== 32'h2) begin fails++; $display("FAIL dis_status: got %h required 00000002", q); end
        wb_write(32'hC, 32'h5);
        tests++;
        if (intr !== 1'b1) begin fails++; $display("FAIL txe_intr: got %b required 1", intr); end
        wb_write(32'hC, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overrun();
        test_partial();
        test_back_to_back();
        test_disable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
